// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one 8x8 single-port RAM between requesters A and B; define RAM_ARB_LOCK_EN for burst lock.
// Grant is combinational in the request cycle, read data returns one cycle later; a losing requester holds its request until granted.
module ram_arbiter #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          a_lock,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_din,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    input  logic          b_lock,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_t;

    sel_t prio_q, prio_d;
    sel_t rd_owner_q, rd_owner_d;
    logic rd_pend_q, rd_pend_d;
    logic gnt_a, gnt_b;

`ifdef RAM_ARB_LOCK_EN
    typedef enum logic [1:0] {
        LK_NONE = 2'd0,
        LK_A    = 2'd1,
        LK_B    = 2'd2
    } lock_t;

    lock_t lock_q, lock_d;

    // A lock owner that still requests wins outright; once it drops req the
    // pointer already names the other side, so plain round-robin takes over.
    always_comb begin
        gnt_a  = 1'b0;
        gnt_b  = 1'b0;
        lock_d = lock_q;
        if (!rst) begin
            if (lock_q == LK_A && a_req) begin
                gnt_a = 1'b1;
            end else if (lock_q == LK_B && b_req) begin
                gnt_b = 1'b1;
            end else if (a_req && (!b_req || prio_q == SEL_A)) begin
                gnt_a = 1'b1;
            end else if (b_req) begin
                gnt_b = 1'b1;
            end
        end
        if (gnt_a) begin
            lock_d = a_lock ? LK_A : LK_NONE;
        end else if (gnt_b) begin
            lock_d = b_lock ? LK_B : LK_NONE;
        end else if ((lock_q == LK_A && !a_req) || (lock_q == LK_B && !b_req)) begin
            lock_d = LK_NONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= LK_NONE;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = a_lock ^ b_lock;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            if (a_req && (!b_req || prio_q == SEL_A)) begin
                gnt_a = 1'b1;
            end else if (b_req) begin
                gnt_b = 1'b1;
            end
        end
    end
`endif

    assign a_gnt = gnt_a;
    assign b_gnt = gnt_b;

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (gnt_a) begin
            ram_we   = a_we;
            ram_addr = a_addr;
            ram_din  = a_din;
        end else if (gnt_b) begin
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_din  = b_din;
        end
    end

    always_comb begin
        prio_d     = prio_q;
        rd_pend_d  = 1'b0;
        rd_owner_d = rd_owner_q;
        if (gnt_a) begin
            prio_d = SEL_B;
        end else if (gnt_b) begin
            prio_d = SEL_A;
        end
        if ((gnt_a && !a_we) || (gnt_b && !b_we)) begin
            rd_pend_d  = 1'b1;
            rd_owner_d = gnt_b ? SEL_B : SEL_A;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q     <= SEL_A;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= SEL_A;
        end else begin
            prio_q     <= prio_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Both ports see the RAM output directly; rvalid alone says whose it is.
    assign a_rdata  = ram_dout;
    assign b_rdata  = ram_dout;
    assign a_rvalid = rd_pend_q && (rd_owner_q == SEL_A);
    assign b_rvalid = rd_pend_q && (rd_owner_q == SEL_B);

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter that shares one single-port synchronous RAM (8 x 8, registered read, one-cycle read latency) between requester A and requester B.
- Each cycle it issues at most one command (read or write) to the RAM and routes the returned read data back to the requester that issued it.
- It sits between the RAM macro and two independent masters, for example a DMA engine and a CPU-side port.

Parameters:
- AW, 3, RAM address width.
- DW, 8, RAM data width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- a_req  in  1  requester A command valid; held until granted.
- a_we  in  1  A command is write (1) or read (0).
- a_addr  in  AW  A address.
- a_din  in  DW  A write data.
- a_gnt  out  1  A command accepted this cycle (combinational).
- a_rvalid  out  1  A read data valid.
- a_rdata  out  DW  A read data.
- a_lock  in  1  A requests burst lock (used only with the optional feature).
- b_req, b_we, b_addr, b_din, b_gnt, b_rvalid, b_rdata, b_lock: same as A, for requester B.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM registered read data.

Behaviour:
- Reset (async, immediate on rst rise):
  - prio pointer = A.
  - Read-tracking registers (rd_pend, rd_owner) cleared.
  - a_rvalid = b_rvalid = 0.
  - Lock state cleared.
  - With no request: ram_we=0, ram_addr=0, ram_din=0.
  - Reset mid-operation: an in-flight read is discarded; no rvalid is produced after reset.
- Arbitration in cycle N (combinational from req and prio):
  - Only one req high: that requester is granted.
  - Both high: the requester named by prio is granted.
  - Neither high: no grant, ram_we=0.
  - Exactly one gnt is high at a time; never both.
- Command drive in the grant cycle:
  - ram_we = granted we.
  - ram_addr = granted addr.
  - ram_din = granted din.
  - With no grant, ram_addr and ram_din = 0 and ram_we = 0.
- Pointer update at the end of a granted cycle:
  - prio = the other requester, so back-to-back contention alternates A, B, A, B.
  - No grant: prio is unchanged.
- Read return:
  - A read granted in cycle N sets rd_pend=1 and rd_owner=granted requester at the edge.
  - In cycle N+1, x_rvalid=1 for the owner and x_rdata = ram_dout; the non-owner's rvalid = 0.
  - The rdata of both ports mirrors ram_dout at all times; it is qualified only by rvalid.
  - Writes produce no rvalid.
- Read-after-write to the same address in consecutive cycles returns the new data, since the RAM has already committed the write.
- A new grant is permitted every cycle; reads are fully pipelined, with one rvalid per read.
- Requester contract:
  - Hold req, we, addr and din stable until gnt.
  - May drop req after gnt, or keep it high to issue the next command.

Optional Feature:
- Macro RAM_ARB_LOCK_EN.
- Defined:
  - If a requester is granted while its lock=1, it keeps ownership. The other requester is not granted while the owner holds both req and lock.
  - Ownership is released when the owner is granted with lock=0, or when the owner's req drops.
  - On release, prio points to the other requester.
  - The lock state register resets to none.
- Not defined: lock inputs are ignored; pure round-robin.

Test Plan:
- Write A then read A: A writes addr 3 data 8'hAA in cycle 1, then reads addr 3 in cycle 2 -> a_gnt in both cycles; a_rvalid=1 and a_rdata=8'hAA in cycle 3; b_rvalid=0 throughout.
- Contention: A and B both request reads every cycle for 4 cycles after reset (addr 0 preloaded 8'h11, addr 1 preloaded 8'h22; A reads addr 0, B reads addr 1) -> grant order A, B, A, B; rvalid alternates one cycle later with the correct 8'h11 / 8'h22 routing.
- Single requester streaming: B alone reads addr 0..7 back-to-back -> b_gnt=1 for 8 consecutive cycles; b_rvalid for 8 consecutive cycles starting 1 cycle later; data in address order.
- Reset mid-read: A read granted, then rst asserted before the next edge and released later -> a_rvalid never asserts; prio=A after reset; ram_we=0.
- Idle: no req for 5 cycles -> no gnt, ram_we=0, prio unchanged, no rvalid.
- Lock (RAM_ARB_LOCK_EN): A requests with lock=1 for 3 cycles while B requests continuously -> a_gnt for 3 cycles; B granted in the cycle after A drops lock; without the macro, grants alternate A, B.
